// File: rtl/multiples_scanner.sv
// multiples_scanner: sweeps num over [lo..hi] (5-bit wrap) and tallies classifier flags; optional SCAN_PAUSE_EN adds a pause input
module multiples_scanner #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
`ifdef SCAN_PAUSE_EN
  input  logic          pause,
`endif
  input  logic          start,
  input  logic [4:0]    lo,
  input  logic [4:0]    hi,
  output logic [4:0]    num,
  input  logic          mul2,
  input  logic          mul3,
  input  logic          mul4,
  input  logic          mul5,
  input  logic          mul235,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt2,
  output logic [CW-1:0] cnt3,
  output logic [CW-1:0] cnt4,
  output logic [CW-1:0] cnt5,
  output logic [CW-1:0] cnt235
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state;
  logic [4:0] hi_q;
  logic [CW-1:0] cnt [5];
  logic [4:0] flags;
  logic adv;
  assign flags = {mul235, mul5, mul4, mul3, mul2};
`ifdef SCAN_PAUSE_EN
  assign adv = !pause;
`else
  assign adv = 1'b1;
`endif
  assign cnt2 = cnt[0];
  assign cnt3 = cnt[1];
  assign cnt4 = cnt[2];
  assign cnt5 = cnt[3];
  assign cnt235 = cnt[4];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      num <= '0;
      hi_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            hi_q <= hi;
            num <= lo;
            busy <= 1'b1;
            state <= SCAN;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
          end
        end
        SCAN: if (adv) begin
          // saturating tallies: only reachable when CW is overridden below 6
          for (int i = 0; i < 5; i++)
            if (flags[i] && cnt[i] != '1) cnt[i] <= cnt[i] + CW'(1);
          if (num == hi_q) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            num <= num + 5'd1;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiples_scanner.sv
// tb_multiples_scanner: directed sweeps against a behavioural classifier, checking timing, sequence and tallies
module tb_multiples_scanner;
  localparam int CW = 6;
`ifdef SCAN_PAUSE_EN
  localparam int PZ = 5;
`else
  localparam int PZ = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0;
  logic [4:0] lo = '0, hi = '0, num;
  logic mul2, mul3, mul4, mul5, mul235, busy, done;
  logic [CW-1:0] cnt2, cnt3, cnt4, cnt5, cnt235;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  assign mul2 = ~num[0];
  assign mul4 = num[1:0] == 2'd0;
  assign mul3 = (num % 5'd3) == 5'd0;
  assign mul5 = (num % 5'd5) == 5'd0;
  assign mul235 = (num % 5'd30) == 5'd0;

  multiples_scanner #(.CW(CW)) dut (
    .clk(clk), .rst(rst),
`ifdef SCAN_PAUSE_EN
    .pause(pause),
`endif
    .start(start), .lo(lo), .hi(hi), .num(num),
    .mul2(mul2), .mul3(mul3), .mul4(mul4), .mul5(mul5), .mul235(mul235),
    .busy(busy), .done(done),
    .cnt2(cnt2), .cnt3(cnt3), .cnt4(cnt4), .cnt5(cnt5), .cnt235(cnt235)
  );

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_cnts(input string tag, input int e2, e3, e4, e5, e235);
    check({tag, "_cnt2"}, cnt2, e2);
    check({tag, "_cnt3"}, cnt3, e3);
    check({tag, "_cnt4"}, cnt4, e4);
    check({tag, "_cnt5"}, cnt5, e5);
    check({tag, "_cnt235"}, cnt235, e235);
  endtask

  task automatic run(input string tag, input logic [4:0] l, h, input int n,
                     input int e2, e3, e4, e5, e235, input bit extra, input bit pz);
    int done_at = 0, nb = 0, bad = 0, extra_cyc;
    logic [4:0] en;
    extra_cyc = pz ? PZ : 0;
    @(negedge clk);
    lo = l; hi = h; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lo = 5'd7; hi = 5'd9;
    en = l;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done) begin
        done_at = c;
        break;
      end
      if (busy) begin
        nb++;
        if (num !== en) bad++;
      end
      start = extra && (c == 3 || c == 32);
      pause = pz && c >= 5 && c <= 9;
      if (!pause || PZ == 0) en = en + 5'd1;
    end
    start = 1'b0; pause = 1'b0;
    check({tag, "_done_cycle"}, done_at, n + 1 + extra_cyc);
    check({tag, "_busy_cycles"}, nb, n + extra_cyc);
    check({tag, "_num_seq_errs"}, bad, 0);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_num_hold"}, num, h);
    check_cnts(tag, e2, e3, e4, e5, e235);
    @(negedge clk);
    check({tag, "_done_pulse_len"}, done, 0);
    check({tag, "_cnt2_stable"}, cnt2, e2);
  endtask

  initial begin
    int nd;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_num", num, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_cnts("rst", 0, 0, 0, 0, 0);

    run("full", 5'd0, 5'd31, 32, 16, 11, 8, 7, 2, 1'b0, 1'b0);
    run("single", 5'd12, 5'd12, 1, 1, 1, 1, 0, 0, 1'b0, 1'b0);
    run("wrap", 5'd30, 5'd1, 4, 2, 2, 1, 2, 2, 1'b0, 1'b0);

    @(negedge clk);
    lo = 5'd0; hi = 5'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_num", num, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check_cnts("abort", 0, 0, 0, 0, 0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    run("five", 5'd5, 5'd5, 1, 0, 0, 0, 1, 0, 1'b0, 1'b0);

    run("extra_start", 5'd0, 5'd31, 32, 16, 11, 8, 7, 2, 1'b1, 1'b0);
    run("pause", 5'd0, 5'd31, 32, 16, 11, 8, 7, 2, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multiples_scanner.md
Name: multiples_scanner

Overview:
Sequential range sweeper that sits around the 5-bit multiples classifier. It drives the classifier's `num` input upstream and consumes its mul2/mul3/mul4/mul5/mul235 flags downstream. On `start` it steps `num` through an inclusive 5-bit range, one value per clock, and tallies how many values raised each flag. It then reports the counts with a one-cycle `done` pulse. It is used by the lab top level to show multiple-counts on LEDs/7-seg.

Parameters:
- CW, 6, counter width; must be ≥6 so a full 32-value sweep cannot overflow.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a sweep; sampled only in IDLE
- lo  in  5  first value of the range; latched on accepted start
- hi  in  5  last value of the range, inclusive; latched on accepted start
- num  out  5  value presented to the classifier
- mul2  in  1  classifier flag for current `num`
- mul3  in  1  classifier flag for current `num`
- mul4  in  1  classifier flag for current `num`
- mul5  in  1  classifier flag for current `num`
- mul235  in  1  classifier flag for current `num`
- busy  out  1  high while in SCAN
- done  out  1  one-cycle pulse when a sweep completes
- cnt2  out  CW  tally of mul2
- cnt3  out  CW  tally of mul3
- cnt4  out  CW  tally of mul4
- cnt5  out  CW  tally of mul5
- cnt235  out  CW  tally of mul235

Behaviour:
- One clock (`clk`); reset `rst` is synchronous and active-high. The reset value of every output is 0: num=0, busy=0, done=0, cnt*=0. State goes to IDLE and latched lo/hi are cleared.
- States are IDLE, SCAN and DONE.
- IDLE:
  - `start`=1 latches lo/hi, clears all cnt* to 0, loads num<=lo, and moves to SCAN.
  - busy=1 from the next cycle.
  - Otherwise cnt* hold their last values.
- SCAN, every cycle:
  - Flags are combinational from the current `num` and are sampled at the rising edge.
  - Each cntX increments by 1 if its flag is 1.
  - If num==hi_latched: go to DONE.
  - Else: num<=num+1, 5-bit modulo, so 31 wraps to 0.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - num holds the last value; cnt* hold.
- Range length N = ((hi-lo) mod 32)+1. lo==hi gives N=1; lo>hi wraps through 31→0; lo=0,hi=31 gives N=32.
- Latency: start edge at cycle 0; SCAN spans cycles 1..N; done=1 in cycle N+1. cnt* are final and stable when done=1 and remain so until the next accepted start.
- `start` is ignored in SCAN and DONE; there is no queuing. lo/hi changes after acceptance have no effect.
- `rst` mid-sweep aborts immediately: all outputs go to 0 on that edge, and no done pulse is produced.
- Counters saturate at 2^CW-1. This is unreachable for CW≥6 but is required for smaller overrides.

Optional Feature:
- Macro: SCAN_PAUSE_EN.
- Defined:
  - Adds input port `pause` (1 bit).
  - In SCAN with pause=1: num, cnt* and state all hold, and flags are not sampled. busy stays 1.
  - `pause` is ignored in IDLE and DONE. rst overrides pause.
- Undefined:
  - No `pause` port exists, and SCAN advances every cycle.

Test Plan:
- rst 2 cycles, then idle -> num=0, busy=0, done=0, all cnt*=0.
- start with lo=0, hi=31, real classifier attached -> busy cycles 1..32; done in cycle 33; cnt2=16, cnt3=11, cnt4=8, cnt5=7, cnt235=2.
- start with lo=12, hi=12 -> busy 1 cycle, done in cycle 2; cnt2=1, cnt3=1, cnt4=1, cnt5=0, cnt235=0.
- Wrap: start with lo=30, hi=1 -> num sequence 30,31,0,1; done in cycle 5; cnt2=2, cnt3=2, cnt4=1, cnt5=2, cnt235=2.
- lo=0, hi=31 sweep; rst at cycle 10; then start with lo=5, hi=5 -> after rst all outputs 0 and no done; the second sweep gives cnt5=1, others 0, done in cycle 2.
- Start pulses at cycles 3 and 32 of a full sweep; with SCAN_PAUSE_EN, pause=1 for cycles 5..9 -> extra starts ignored and counts unchanged; with pause, done moves from cycle 33 to cycle 38 with identical counts.
